// File: rtl/cfu_acc_requant.sv
// Accumulates 4-lane MAC partial sums and requantizes each finished element to int8.
// The pipeline runs S1 (biased sum), S2 (SRDHM), S3 (rounding shift), then the output register (offset and clamp).
module cfu_acc_requant (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic signed [31:0] in_sum,
  input  logic               in_last,
  input  logic signed [31:0] bias,
  input  logic signed [31:0] multiplier,
  input  logic        [4:0]  shift,
  input  logic signed [31:0] out_offset,
  input  logic signed [7:0]  act_min,
  input  logic signed [7:0]  act_max,
  output logic               out_valid,
  input  logic               out_ready,
  output logic signed [7:0]  out_data
);

  typedef struct packed {
    logic        [4:0]  shift;
    logic signed [31:0] offset;
    logic signed [7:0]  act_min;
    logic signed [7:0]  act_max;
  } qparam_t;

  localparam logic signed [31:0] INT_MIN = 32'sh8000_0000;

  logic               stall, accept;
  logic signed [31:0] acc;
  logic               s1_valid, s2_valid, s3_valid;
  logic signed [31:0] s1_val, s1_mult, s2_x, s3_y;
  qparam_t            s1_p, s2_p, s3_p;

  logic signed [63:0] prod, prod_rnd, prod_q;
  logic signed [31:0] x_next;
  logic        [31:0] mask, rem, thr;
  logic signed [31:0] y_shr, y_next;
  logic signed [31:0] z, z_clamp;

  // A result held for a stalled consumer freezes every stage, including the accumulator.
  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;
  assign accept   = in_valid & in_ready;

  // NOTE: every always_comb output gets a default before any conditional override, so no latch is inferred.
  always_comb begin
    prod     = 64'(s1_val) * 64'(s1_mult);
    prod_rnd = prod + (prod[63] ? -64'sd1073741823 : 64'sd1073741824);
    prod_q   = prod_rnd >>> 31;
    // Arithmetic shift floors; bump negative inexact quotients to truncate toward zero.
    if (prod_rnd[63] && (prod_rnd[30:0] != '0)) prod_q = prod_q + 64'sd1;
    x_next = prod_q[31:0];
    if (s1_val == INT_MIN && s1_mult == INT_MIN) x_next = 32'sh7fff_ffff;
  end

  always_comb begin
    mask   = (32'd1 << s2_p.shift) - 32'd1;
    rem    = s2_x & mask;
    thr    = (mask >> 1) + {31'd0, s2_x[31]};
    y_shr  = s2_x >>> s2_p.shift;
    y_next = y_shr + ((rem > thr) ? 32'sd1 : 32'sd0);
  end

  // Lower clamp first so an inverted range resolves to act_max.
  always_comb begin
    z       = s3_y + s3_p.offset;
    z_clamp = z;
    if (z_clamp < 32'($signed(s3_p.act_min))) z_clamp = 32'($signed(s3_p.act_min));
    if (z_clamp > 32'($signed(s3_p.act_max))) z_clamp = 32'($signed(s3_p.act_max));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc       <= '0;
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      s3_valid  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      if (accept) acc <= in_last ? 32'sd0 : acc + in_sum;
      if (!stall) begin
        s1_valid  <= accept & in_last;
        s2_valid  <= s1_valid;
        s3_valid  <= s2_valid;
        out_valid <= s3_valid;
        if (s3_valid) out_data <= z_clamp[7:0];
      end
    end
  end

  // NOTE: payload registers carry no reset; the valid bits alone decide whether their contents are used.
  always_ff @(posedge clk) begin
    if (!stall) begin
      if (accept && in_last) begin
        s1_val  <= acc + in_sum + bias;
        s1_mult <= multiplier;
        s1_p    <= '{shift: shift, offset: out_offset, act_min: act_min, act_max: act_max};
      end
      s2_x <= x_next;
      s2_p <= s1_p;
      s3_y <= y_next;
      s3_p <= s2_p;
    end
  end

endmodule

// File: tb/tb_cfu_acc_requant.sv
// Self-checking bench for cfu_acc_requant: a reference model fills a scoreboard
// queue at each accepted last beat and a negedge monitor pops it on each output transfer.
module tb_cfu_acc_requant;

  logic               clk = 1'b0;
  logic               reset_n, in_valid, in_ready, in_last;
  logic               out_valid, out_ready;
  logic signed [31:0] in_sum, bias, multiplier, out_offset;
  logic        [4:0]  shift;
  logic signed [7:0]  act_min, act_max, out_data;

  int                 n_checks = 0;
  int                 n_pass   = 0;
  int                 tb_acc   = 0;
  int                 exp_q[$];
  int                 mon_e;
  logic               prev_stall = 1'b0;
  logic signed [7:0]  prev_data  = '0;
  int                 n;

  always #5 clk = ~clk;

  cfu_acc_requant dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sum    (in_sum),
    .in_last   (in_last),
    .bias      (bias),
    .multiplier(multiplier),
    .shift     (shift),
    .out_offset(out_offset),
    .act_min   (act_min),
    .act_max   (act_max),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // Reference: exact 64-bit SRDHM, then round-half-away-from-zero division by 2^shift.
  function automatic int ref_requant(input int s1, input int mult, input int sh,
                                     input int off, input int mn, input int mx);
    int     int_min;
    longint p, d, xl;
    int     x, y, z;
    int_min = 32'h8000_0000;
    if (s1 == int_min && mult == int_min) begin
      x = 32'h7fff_ffff;
    end else begin
      p = longint'(s1) * longint'(mult);
      p = p + ((p >= 0) ? 64'sd1073741824 : (64'sd1 - 64'sd1073741824));
      x = int'(p / 64'sd2147483648);
    end
    d  = 64'sd1 << sh;
    xl = longint'(x);
    if (xl >= 0) y = int'((xl + d / 2) / d);
    else         y = int'(-((-xl + d / 2) / d));
    z = y + off;
    if (z < mn) z = mn;
    if (z > mx) z = mx;
    return z;
  endfunction

  task automatic set_params(input int b, input int m, input int s, input int o,
                            input int mn, input int mx);
    bias       = b;
    multiplier = m;
    shift      = 5'(s);
    out_offset = o;
    act_min    = 8'(mn);
    act_max    = 8'(mx);
  endtask

  // Presents one beat, waits (bounded) until it is accepted, and scores it.
  task automatic drive_beat(input int sum, input bit last, input bit use_const, input int exp_const);
    int k;
    int e;
    in_valid = 1'b1;
    in_sum   = sum;
    in_last  = last;
    #1;
    k = 0;
    while (!in_ready && k < 50) begin
      @(posedge clk); #1;
      out_ready = 1'b1;
      #1;
      k++;
    end
    if (!in_ready) check("accept_timeout", in_ready, 1);
    @(posedge clk);
    if (last) begin
      e = use_const ? exp_const
                    : ref_requant(tb_acc + sum + int'(bias), int'(multiplier), int'(shift),
                                  int'(out_offset), int'(act_min), int'(act_max));
      exp_q.push_back(e);
      tb_acc = 0;
    end else begin
      tb_acc = tb_acc + sum;
    end
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain();
    int k;
    @(posedge clk); #1;
    out_ready = 1'b1;
    k = 0;
    while (exp_q.size() != 0 && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    check("drain_empty", exp_q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      if (prev_stall) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, prev_data);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_out", out_valid, 0);
        end else begin
          mon_e = exp_q.pop_front();
          check("out_data", out_data, mon_e);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end else begin
      prev_stall = 1'b0;
    end
  end

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_sum    = '0;
    out_ready = 1'b0;
    set_params(0, 0, 0, 0, -128, 127);
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_in_ready", in_ready, 1);
    reset_n   = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;

    // Half multiply, plus latency from the accepting edge.
    set_params(0, 32'h4000_0000, 0, 0, -128, 127);
    drive_beat(100, 1'b1, 1'b1, 50);
    n = 0;
    while (!out_valid && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    check("latency", n, 3);
    drain();

    // Accumulation over three beats: (10+20+30+40)=100 -> 100 -> 50 -> -78.
    set_params(40, 32'h7fff_ffff, 1, -128, -128, 127);
    drive_beat(10, 1'b0, 1'b0, 0);
    drive_beat(20, 1'b0, 1'b0, 0);
    drive_beat(30, 1'b1, 1'b1, -78);
    drain();

    // Rounding of ties away from zero, issued back to back.
    set_params(0, 32'h7fff_ffff, 1, 0, -128, 127);
    drive_beat(3, 1'b1, 1'b1, 2);
    drive_beat(-3, 1'b1, 1'b1, -2);
    drain();

    // Saturation: clamp high, doubled INT_MIN, and an inverted clamp range.
    set_params(0, 32'h4000_0000, 0, 0, -128, 127);
    drive_beat(1000, 1'b1, 1'b1, 127);
    set_params(0, 32'h8000_0000, 0, 0, -128, 127);
    drive_beat(32'h8000_0000, 1'b1, 1'b1, 127);
    set_params(0, 32'h4000_0000, 0, 0, 5, -5);
    drive_beat(0, 1'b1, 1'b1, -5);
    drain();

    // Backpressure: two results queue up behind a stalled consumer.
    set_params(0, 32'h4000_0000, 0, 0, -128, 127);
    out_ready = 1'b0;
    drive_beat(40, 1'b1, 1'b1, 20);
    drive_beat(60, 1'b1, 1'b1, 30);
    n = 0;
    while (!out_valid && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    check("bp_valid", out_valid, 1);
    check("bp_in_ready", in_ready, 0);
    repeat (4) @(posedge clk);
    #1;
    check("bp_still_stalled", in_ready, 0);
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_first", out_valid, 1);
    @(negedge clk);
    check("bp_second", out_valid, 1);
    @(negedge clk);
    check("bp_empty", out_valid, 0);
    drain();

    // Reset mid-accumulation with a result in flight; neither may survive.
    set_params(0, 32'h4000_0000, 0, 0, -128, 127);
    drive_beat(100, 1'b1, 1'b1, 50);
    drive_beat(7, 1'b0, 1'b0, 0);
    drive_beat(8, 1'b0, 1'b0, 0);
    reset_n = 1'b0;
    exp_q.delete();
    tb_acc = 0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_out_data", out_data, 0);
    check("mid_rst_in_ready", in_ready, 1);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    drive_beat(5, 1'b1, 1'b1, 3);
    drain();

    // Random beats, parameters and consumer stalls against the reference model.
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      set_params(int'($urandom_range(0, 2000)) - 1000, int'($urandom),
                 int'($urandom_range(0, 8)), int'($urandom_range(0, 100)) - 50,
                 -int'($urandom_range(0, 128)), int'($urandom_range(0, 127)));
      drive_beat(int'($urandom_range(0, 4000)) - 2000, $urandom_range(0, 2) == 0, 1'b0, 0);
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
